// File: rtl/wb_bus_arbiter_pkg.sv
// rtl/wb_bus_arbiter_pkg.sv - shared encodings and constants for the Wishbone bus arbiter
package wb_bus_arbiter_pkg;

  // 2-bit arbiter state register encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_TERM  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Stalled cycles before the watchdog terminates a transfer
  localparam int DEFAULT_TIMEOUT = 255;

  // Position of the bus-timeout line in the CPU interrupt vector
  localparam int BUS_TIMEOUT_IRQ_BIT = 6;

endpackage

// File: rtl/wb_bus_arbiter_rr_prio_pick.sv
// rtl/wb_bus_arbiter_rr_prio_pick.sv - combinational round-robin / fixed-priority winner selector
module rr_prio_pick
  import wb_bus_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          mode,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  int pick;

  // Pick the winner: lowest set index, or first set index after last (wrapping)
  always_comb begin
    pick = 0;
    if (mode) begin
      // descending offset so the nearest requester after last is assigned last and wins
      for (int k = N; k >= 1; k--) begin
        for (int j = 0; j < N; j++) begin
          if (req[j] && (j == ((int'(last) + k) % N))) begin
            pick = j;
          end
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin
          pick = i;
        end
      end
    end
    onehot = '0;
    for (int j = 0; j < N; j++) begin
      onehot[j] = (j == pick) && (|req);
    end
    idx = IW'(pick);
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - Wishbone master arbiter with cyc-envelope grants and bus watchdog
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTER = 2,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT,
  parameter int TW         = 8,
  parameter int GW         = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  roundORpriority,
  input  logic [NUM_MASTER-1:0] wbm_cyc_i,
  input  logic [NUM_MASTER-1:0] wbm_stb_i,
  input  logic                  wbs_ack_i,
  input  logic                  wbs_err_i,
  input  logic                  wbs_rty_i,
  output logic [NUM_MASTER-1:0] o_grant,
  output logic [GW-1:0]         o_grant_idx,
  output logic                  o_bus_busy,
  output logic                  o_timeout_err,
  output logic                  o_timeout_irq
);

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t                state, state_n;
  logic [TW-1:0]         cnt, cnt_n;
  logic [GW-1:0]         last, last_n;
  logic [NUM_MASTER-1:0] grant_n;
  logic [GW-1:0]         idx_n;
  logic                  busy_n;
  logic                  err_n;
  logic [NUM_MASTER-1:0] pick_onehot;
  logic [GW-1:0]         pick_idx;
  logic                  cyc_g;
  logic                  stall;

  rr_prio_pick #(
    .N  (NUM_MASTER),
    .IW (GW)
  ) u_pick (
    .req    (wbm_cyc_i),
    .last   (last),
    .mode   (roundORpriority),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  // Granted master's view of the bus: its cyc, and whether its strobe is stalled
  always_comb begin
    cyc_g = wbm_cyc_i[o_grant_idx];
    stall = wbm_stb_i[o_grant_idx] && !wbs_ack_i && !wbs_err_i && !wbs_rty_i;
  end

  // Next-state and next-output logic for arbitration, ownership and watchdog
  always_comb begin
    state_n = state;
    grant_n = o_grant;
    idx_n   = o_grant_idx;
    busy_n  = o_bus_busy;
    err_n   = 1'b0;
    cnt_n   = cnt;
    last_n  = last;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (|wbm_cyc_i) begin
          grant_n = pick_onehot;
          idx_n   = pick_idx;
          busy_n  = 1'b1;
          last_n  = pick_idx;
          state_n = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!cyc_g) begin
          grant_n = '0;
          busy_n  = 1'b0;
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else if (stall) begin
          if (cnt == TO_LAST) begin
            err_n   = 1'b1;
            cnt_n   = '0;
            state_n = ST_TERM;
          end else if (cnt != '1) begin
            cnt_n = cnt + TW'(1);
          end
        end else begin
          cnt_n = '0;
        end
      end
      ST_TERM: begin
        // slave responses here are ignored; the interconnect gates them with the err pulse
        state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!cyc_g) begin
          grant_n = '0;
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: begin
        grant_n = '0;
        busy_n  = 1'b0;
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any grant without an err pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      o_grant       <= '0;
      o_grant_idx   <= '0;
      o_bus_busy    <= 1'b0;
      o_timeout_err <= 1'b0;
      o_timeout_irq <= 1'b0;
      cnt           <= '0;
      last          <= GW'(NUM_MASTER - 1);
    end else begin
      state         <= state_n;
      o_grant       <= grant_n;
      o_grant_idx   <= idx_n;
      o_bus_busy    <= busy_n;
      o_timeout_err <= err_n;
      o_timeout_irq <= err_n;
      cnt           <= cnt_n;
      last          <= last_n;
    end
  end

endmodule
